gerador_operandos: RTL and testbench
====================================

Name: gerador_operandos

Overview:
- Upstream stimulus stage for the logic-gate block: drives its operand buses a and b.
- Steps through every (a,b) operand pair, holding each pair for a programmable number of cycles.
- Start/pause/done handshake lets a top-level controller or bench sequence the run.
- Operand bus width matches the gate block (3 bits default).

Parameters:
- WIDTH, 3, width of each operand bus a and b; legal values 2, 3, 4.
- DWELL, 4, cycles each operand pair is held valid; legal range 1..255.

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a run; sampled only in IDLE
- pause  input  1  freeze the sequence while high
- a  output  WIDTH  operand A to the gate block
- b  output  WIDTH  operand B to the gate block
- valid  output  1  a/b hold a live pair this cycle
- busy  output  1  high in RUN and HOLD
- done  output  1  one-cycle pulse at end of run
- idx  output  2*WIDTH  index of the current pair, 0 .. 2^(2*WIDTH)-1

Behaviour:
- Reset is asynchronous and active-low:
  - Clock is clk; reset is rst_n, asynchronous, active-low.
  - While rst_n=0, all outputs are 0 and the FSM is in IDLE, dwell counter 0, index 0.
  - Release takes effect on the next clk edge.
- FSM states are IDLE, RUN, HOLD and DONE.
- IDLE:
  - valid=0, busy=0, a=b=0.
  - start=1 at an edge moves to RUN. At that same edge a=0, b=0, idx=0, valid=1, busy=1, and the dwell counter loads 1.
- RUN:
  - valid=1. The pair is held while the dwell counter is below DWELL, and the counter increments each cycle.
  - When the counter equals DWELL and the pair is not the last one, advance at the next edge: idx+1, {a,b}=idx+1 (a is the MSBs, b the LSBs), counter=1.
  - Each pair is therefore valid for exactly DWELL un-paused cycles.
- Last pair:
  - The last pair is idx = 2^(2*WIDTH)-1, i.e. a=b=all-ones.
  - After its DWELL cycles, the FSM moves to DONE: valid=0, busy=0, done=1, with a, b and idx holding their last values.
- DONE:
  - Lasts exactly one cycle, then IDLE. done returns to 0 and a=b=idx=0.
- pause:
  - In RUN, pause=1 at an edge moves to HOLD. valid=0, busy stays 1, and a, b, idx and the counter freeze.
  - In HOLD, pause=0 at an edge returns to RUN with valid=1. The remaining dwell continues from the frozen count; the current pair is not restarted.
- Simultaneous events:
  - pause has priority over the dwell-expiry advance in the same cycle.
  - start is ignored outside IDLE.
  - pause is ignored in IDLE and DONE.
- Width and wrap rules:
  - idx is a 2*WIDTH-bit counter and never wraps during a run; the end-of-run detect precedes any overflow.
  - The dwell counter is 8 bits.
- Reset mid-operation:
  - Immediate return to IDLE with all outputs 0. No done pulse.
- Total valid cycles per run: 2^(2*WIDTH) × DWELL, which is 256 for the defaults.

Optional Feature:
- Macro: GERADOR_LFSR_EN
- Defined: pair ordering comes from a 2*WIDTH-bit Fibonacci LFSR.
  - Taps: x^4+x^3+1 (WIDTH=2), x^6+x^5+1 (WIDTH=3), x^8+x^6+x^5+x^4+1 (WIDTH=4).
  - Pair 0 is always {a,b}=0.
  - Pair 1 loads the LFSR seed 1. Each later advance shifts the LFSR once.
  - idx still counts 0..2^(2*WIDTH)-1 and the run ends after idx reaches its maximum, so every pair appears exactly once.
  - Dwell, pause and done timing are unchanged.
- Undefined: sequential ordering {a,b}=idx, as described above; no LFSR logic is synthesized.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, then start=0 for 10 cycles -> a=b=0, valid=busy=done=0 throughout.
- Basic run (defaults): start pulse at edge 0 -> edge 0: a=000,b=000,valid=1. Edge 4: a=000,b=001,idx=1. Edge 8: idx=2. Edge 252: a=111,b=111. Edge 256: done=1,valid=0. Edge 257: done=0, busy=0.
- Pause mid-pair: pause=1 for 5 cycles, issued 2 cycles into idx=5 -> valid=0 and a/b frozen at 000/101 for 5 cycles. After release, idx=5 stays valid for exactly 2 more cycles, then idx=6. Total run grows by 5 cycles.
- Ignored start: start pulsed at idx=10 and during DONE -> no restart; the sequence and the done timing are identical to the basic run.
- Async reset mid-run: rst_n=0 between edges at idx=30 -> outputs 0 immediately with no clock. After release, the block stays IDLE until start; no done pulse.
- GERADOR_LFSR_EN, DWELL=1: run with the macro defined -> pairs 0,1 are {a,b}=000000 and 000001. All 64 codes are seen exactly once, with done one cycle after the 64th pair.

Source files
------------

// File: rtl/gerador_operandos.sv
// gerador_operandos
//   Stimulus source for the logic-gate block. It walks through every (a,b)
//   operand pair and holds each pair for DWELL un-paused cycles. A
//   start/pause/done handshake lets a controller or a bench sequence the run.
//
//   Parameters
//     WIDTH : width of each operand bus (2, 3 or 4)
//     DWELL : cycles each pair stays valid (1..255)
//
//   Ports
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     start : begins a run; only looked at while idle
//     pause : freezes the sequence while high
//     a, b  : operand buses to the gate block (a = MSBs of the pair code)
//     valid : a/b hold a live pair this cycle
//     busy  : a run is in progress (running or paused)
//     done  : one-cycle pulse after the last pair
//     idx   : index of the current pair, 0 .. 2^(2*WIDTH)-1
//
//   Optional build macro GERADOR_LFSR_EN
//     When defined, the pair codes come from a 2*WIDTH-bit Fibonacci LFSR
//     instead of being equal to idx. Pair 0 is still all-zeros and pair 1 is
//     the seed 1, so every code still appears exactly once per run.

module gerador_operandos #(
  parameter int WIDTH = 3,
  parameter int DWELL = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               pause,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic               valid,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] idx
);

  localparam int IW = 2 * WIDTH;
  localparam logic [IW-1:0] IDX_LAST = '1;
  localparam logic [7:0]    DWELL_C  = 8'(DWELL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;

  // Pulses from the sequencer telling the pair-code logic what to do.
  logic advancePair;
  logic clearPair;

  // State, dwell counter and pair index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Sequencer. RUN and HOLD share one decision: pause wins and parks the
  // block in HOLD with everything frozen; otherwise the dwell either keeps
  // counting or the pair ends. Resuming from HOLD counts the resume cycle
  // as the next dwell cycle, so a paused pair still gets exactly DWELL
  // valid cycles in total. A pair whose dwell was already complete when
  // the pause hit advances straight away on resume.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    advancePair = 1'b0;
    clearPair   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          cnt_d     = 8'd1;
          idx_d     = '0;
          clearPair = 1'b1;
        end
      end
      RUN, HOLD: begin
        if (pause) begin
          state_d = HOLD;
        end else begin
          state_d = RUN;
          if (cnt_q < DWELL_C) begin
            cnt_d = cnt_q + 8'd1;
          end else if (idx_q == IDX_LAST) begin
            // End of run is detected before idx could overflow.
            state_d = DONE;
          end else begin
            idx_d       = idx_q + 1'b1;
            cnt_d       = 8'd1;
            advancePair = 1'b1;
          end
        end
      end
      DONE: begin
        state_d   = IDLE;
        cnt_d     = 8'd0;
        idx_d     = '0;
        clearPair = 1'b1;
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = 8'd0;
        idx_d     = '0;
        clearPair = 1'b1;
      end
    endcase
  end

`ifdef GERADOR_LFSR_EN
  logic [IW-1:0] pair_q, pair_d;
  logic [IW-1:0] lfsrNext;
  logic          feedback;

  // Maximal-length feedback polynomials for each supported pair width.
  if (WIDTH == 2) begin : gFb4
    assign feedback = pair_q[3] ^ pair_q[2];
  end else if (WIDTH == 3) begin : gFb6
    assign feedback = pair_q[5] ^ pair_q[4];
  end else begin : gFb8
    assign feedback = pair_q[7] ^ pair_q[5] ^ pair_q[4] ^ pair_q[3];
  end

  assign lfsrNext = {pair_q[IW-2:0], feedback};

  // Pair code: zero for pair 0, seed 1 for pair 1, then one LFSR shift per
  // advance. The LFSR never visits zero, so zero plus its 2^IW-1 states
  // cover every code once.
  always_comb begin
    pair_d = pair_q;
    if (clearPair) begin
      pair_d = '0;
    end else if (advancePair) begin
      pair_d = (idx_q == '0) ? {{(IW-1){1'b0}}, 1'b1} : lfsrNext;
    end
  end

  // Pair code register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_q <= '0;
    end else begin
      pair_q <= pair_d;
    end
  end

  assign {a, b} = pair_q;
`else
  // Sequential ordering: the pair code is the index itself.
  assign {a, b} = idx_q;
`endif

  assign idx   = idx_q;
  assign valid = (state_q == RUN);
  assign busy  = (state_q == RUN) || (state_q == HOLD);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_gerador_operandos.sv
// Directed bench for gerador_operandos (WIDTH=3). The default build checks
// the sequential ordering with DWELL=4; a build with GERADOR_LFSR_EN checks
// the LFSR ordering with DWELL=1.

module tb_gerador_operandos;

  localparam int W = 3;
`ifdef GERADOR_LFSR_EN
  localparam int DW = 1;
`else
  localparam int DW = 4;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         pause;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         valid;
  logic         busy;
  logic         done;
  logic [5:0]   idx;

  int checks = 0;
  int errors = 0;

  gerador_operandos #(.WIDTH(W), .DWELL(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .pause (pause),
    .a     (a),
    .b     (b),
    .valid (valid),
    .busy  (busy),
    .done  (done),
    .idx   (idx)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observed outputs packed as {done,busy,valid,a,b,idx}.
  function automatic logic [31:0] observed();
    return 32'({done, busy, valid, a, b, idx});
  endfunction

`ifndef GERADOR_LFSR_EN
  function automatic logic [31:0] packExp(bit d, bit bz, bit v, int i);
    logic [5:0] i6;
    i6 = 6'(i);
    return 32'({d, bz, v, i6, i6});
  endfunction

  // Expected outputs right after edge e of a run (edge 0 is the start edge),
  // with pause sampled high at edges p .. p+l-1. Paused edges hold the pair
  // seen after edge p-1; later edges behave as an un-paused run shifted by l.
  function automatic logic [31:0] expRun(int e, int p, int l);
    int eff;
    if (l > 0 && e >= p && e < p + l) return packExp(1'b0, 1'b1, 1'b0, (p - 1) / DW);
    eff = (l > 0 && e >= p + l) ? e - l : e;
    if (eff < 64 * DW) return packExp(1'b0, 1'b1, 1'b1, eff / DW);
    if (eff == 64 * DW) return packExp(1'b1, 1'b0, 1'b0, 63);
    return 32'd0;
  endfunction

  // One full run from start to a cycle after returning idle, checked at every
  // edge. pokeStart raises start at idx=10 and during the done cycle.
  task automatic applyStimulus(input int p, input int l, input bit pokeStart,
                               input string name);
    int last;
    last = 64 * DW + 2 + l;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput($sformatf("%s e=0", name), observed(), expRun(0, p, l));
    for (int e = 1; e <= last; e++) begin
      pause = (l > 0 && e >= p && e < p + l);
      start = pokeStart && (e == 41 || e == 64 * DW + 1 + l);
      tick();
      checkOutput($sformatf("%s e=%0d", name, e), observed(), expRun(e, p, l));
    end
    start = 1'b0;
    pause = 1'b0;
  endtask
`endif

  initial begin
`ifdef GERADOR_LFSR_EN
    logic [63:0] seen;
    logic [5:0]  code;
`endif
    rst_n = 1'b0;
    start = 1'b0;
    pause = 1'b0;

    // Reset held for three cycles, then ten idle cycles.
    repeat (3) tick();
    checkOutput("reset outputs", observed(), 32'd0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("idle %0d", i), observed(), 32'd0);
    end

`ifndef GERADOR_LFSR_EN
    $display("[TB] basic run");
    applyStimulus(0, 0, 1'b0, "basic");

    $display("[TB] pause of 5 cycles two cycles into idx=5");
    applyStimulus(22, 5, 1'b0, "pause");

    $display("[TB] start pulses during the run and during done");
    applyStimulus(0, 0, 1'b1, "ignstart");

    $display("[TB] async reset mid-run");
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (120) tick();
    checkOutput("pre-reset idx", 32'(idx), 32'd30);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async reset outputs", observed(), 32'd0);
    tick();
    checkOutput("reset held", observed(), 32'd0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput($sformatf("post-reset idle %0d", i), observed(), 32'd0);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("restart", observed(), packExp(1'b0, 1'b1, 1'b1, 0));
`else
    $display("[TB] LFSR ordering, DWELL=1");
    seen  = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("lfsr pair0", observed(), 32'({3'b011, 6'd0, 6'd0}));
    code = {a, b};
    seen[code] = 1'b1;
    for (int e = 1; e < 64; e++) begin
      tick();
      checkOutput($sformatf("lfsr idx e=%0d", e), 32'({valid, busy, idx}),
                  32'({2'b11, 6'(e)}));
      code = {a, b};
      if (e == 1) checkOutput("lfsr pair1", 32'(code), 32'd1);
      checkOutput($sformatf("lfsr unique e=%0d", e), 32'(seen[code]), 32'd0);
      seen[code] = 1'b1;
    end
    checkOutput("lfsr coverage", 32'(seen == '1), 32'd1);
    tick();
    checkOutput("lfsr done", 32'({done, busy, valid}), 32'b100);
    tick();
    checkOutput("lfsr idle", observed(), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
